// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of an RV32I pipeline.
//
// A load or store presented in M is launched toward the data memory through a
// four-state handshake:
//   IDLE -> REQ -> (load) WAIT -> DONE -> IDLE
//                  (store) -------> DONE -> IDLE
// Request fields are captured on the launch edge and held stable while REQ is
// active. Load data is lane-selected and extended into mem_resultM.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   validM            live instruction in M
//   mem_readM/WriteM  load / store strobes (both high is a fault)
//   funct3M           RV32I load/store width + signedness
//   alu_outM          byte address
//   rs2_dataM         store data
//   dmem_req/we       request strobe / write enable
//   dmem_addr         word-aligned address
//   dmem_wdata/be     lane-replicated store data / byte enables
//   dmem_ready        request accepted
//   dmem_rvalid/rdata load data return
//   mem_resultM       extended load result
//   stallM            freeze upstream stages and MEM/WB input
//   access_fault      misaligned or illegal access (IDLE only)
module mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            validM,
  input  logic            mem_readM,
  input  logic            mem_writeM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] alu_outM,
  input  logic [XLEN-1:0] rs2_dataM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] mem_resultM,
  output logic            stallM,
  output logic            access_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] result_q;

  logic [1:0]      lane;
  logic            is_load, is_store;
  logic            legal_f3, aligned;
  logic            active, launch, fault;
  logic [XLEN-1:0] wdata_d;
  logic [3:0]      be_d;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_fmt;

  // Access decode, only meaningful in IDLE
  always_comb begin
    lane     = alu_outM[1:0];
    is_load  = mem_readM & ~mem_writeM;
    is_store = mem_writeM & ~mem_readM;

    legal_f3 = 1'b0;
    case (funct3M)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = is_load;
      default:                legal_f3 = 1'b0;
    endcase

    aligned = 1'b1;
    case (funct3M[1:0])
      2'b01:   aligned = ~lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b1;
    endcase

    // Reset is treated as "no instruction" so nothing launches or faults
    active = rst_n & validM & (state_q == StIdle);
    launch = active & (is_load | is_store) & legal_f3 & aligned;
    fault  = active & (mem_readM | mem_writeM) & ~launch;
  end

  // Lane placement of store data and byte enables
  always_comb begin
    wdata_d = rs2_dataM;
    be_d    = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        wdata_d = {4{rs2_dataM[7:0]}};
        be_d    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata_d = {2{rs2_dataM[15:0]}};
        be_d    = 4'b0011 << lane;
      end
      default: begin
        wdata_d = rs2_dataM;
        be_d    = 4'b1111;
      end
    endcase
  end

  // Load extraction using the lane captured at launch
  always_comb begin
    rdata_shifted = dmem_rdata >> {lane_q, 3'b000};
    load_fmt      = rdata_shifted;
    case (funct3_q)
      3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_fmt = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_fmt = {16'd0, rdata_shifted[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (launch) state_d = StReq;
      StReq:  if (dmem_ready) state_d = we_q ? StDone : StWait;
      // rvalid in the accepting REQ cycle never reaches here
      StWait: if (dmem_rvalid) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      funct3_q <= 3'b000;
      lane_q   <= 2'b00;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        we_q     <= is_store;
        addr_q   <= {alu_outM[XLEN-1:2], 2'b00};
        wdata_q  <= wdata_d;
        be_q     <= be_d;
        funct3_q <= funct3M;
        lane_q   <= lane;
      end
      if (state_q == StWait && dmem_rvalid) begin
        result_q <= load_fmt;
      end
    end
  end

  always_comb begin
    dmem_req     = rst_n & (state_q == StReq);
    dmem_we      = we_q;
    dmem_addr    = addr_q;
    dmem_wdata   = wdata_q;
    dmem_be      = be_q;
    mem_resultM  = result_q;
    stallM       = rst_n & ((state_q == StReq) | (state_q == StWait) | launch);
    access_fault = fault;
  end

endmodule
